sgpr_rmw_wr_pipe: RTL and testbench



---
 rtl/sgpr_pkg.sv | 26 ++
 rtl/sgpr_rr_arbiter.sv | 55 +++++
 rtl/sgpr_rmw_wr_pipe.sv | 179 +++++++++++++++++
 tb/tb_sgpr_rmw_wr_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgpr_pkg.sv
// Shared widths, arbitration-mode encodings and requester port indices for the
// scalar register file write path.
package sgpr_pkg;

   localparam int SGPR_ADDR_W = 9;
   localparam int SGPR_WORD_W = 32;
   localparam int SGPR_LANES  = 4;
   localparam int WFID_W      = 6;

   typedef enum int {
      ARB_RR    = 0,
      ARB_FIXED = 1
   } arb_mode_e;

   localparam int SIMD0 = 0;
   localparam int SIMD1 = 1;
   localparam int SIMD2 = 2;
   localparam int SIMD3 = 3;
   localparam int SIMF0 = 4;
   localparam int SIMF1 = 5;
   localparam int SIMF2 = 6;
   localparam int SIMF3 = 7;
   localparam int LSU   = 8;
   localparam int SALU  = 9;

endpackage

// File: rtl/sgpr_rr_arbiter.sv
// Single-grant arbiter over the write requesters: round-robin from a rotating
// pointer, or fixed lowest-index priority. No grant while rst is high.
module sgpr_rr_arbiter
   import sgpr_pkg::*;
#(
   parameter int  NUM_PORTS = 10,
   parameter int  ARB_MODE  = 0,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] gnt,
   output logic                 gnt_any,
   output logic [IDX_W-1:0]     gnt_idx
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   // First pass covers ports at or above the pointer, second pass wraps to the bottom.
   always_comb begin
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (!rst) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_any && req[i] && (ARB_MODE == ARB_FIXED || IDX_W'(i) >= ptr_q)) begin
               gnt_any = 1'b1;
               gnt_idx = IDX_W'(i);
               gnt[i]  = 1'b1;
            end
         end
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_any && req[i]) begin
               gnt_any = 1'b1;
               gnt_idx = IDX_W'(i);
               gnt[i]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (ARB_MODE != ARB_FIXED && gnt_any) begin
         ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/sgpr_rmw_wr_pipe.sv
// Masked-write front-end for the scalar register file: arbitration, two-stage
// read-modify-write with same-address forwarding, and a completion pulse.
module sgpr_rmw_wr_pipe #(
   parameter int  NUM_PORTS = 10,
   parameter int  ADDR_W    = sgpr_pkg::SGPR_ADDR_W,
   parameter int  WORD_W    = sgpr_pkg::SGPR_WORD_W,
   parameter int  LANES     = sgpr_pkg::SGPR_LANES,
   parameter int  WFID_W    = sgpr_pkg::WFID_W,
   parameter int  ARB_MODE  = 0,
   localparam int PORT_W    = $clog2(NUM_PORTS),
   localparam int DATA_W    = LANES * WORD_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req_valid,
   output logic [NUM_PORTS-1:0]          req_ready,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
   input  logic [NUM_PORTS*LANES-1:0]    req_wr_en,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_mask,
   input  logic [NUM_PORTS*WFID_W-1:0]   req_wfid,
   output logic [ADDR_W-1:0]             rf_rd_addr,
   input  logic [DATA_W-1:0]             rf_rd_data,
   output logic [LANES-1:0]              rf_wr_en,
   output logic [ADDR_W-1:0]             rf_wr_addr,
   output logic [DATA_W-1:0]             rf_wr_data,
   output logic                          done_valid,
   output logic [PORT_W-1:0]             done_port,
   output logic [WFID_W-1:0]             done_wfid,
   output logic [ADDR_W-1:0]             done_addr,
   output logic [LANES-1:0]              done_wr_en
);

   logic [NUM_PORTS-1:0] gnt;
   logic                 gnt_any;
   logic [PORT_W-1:0]    gnt_idx;

   logic [ADDR_W-1:0] g_addr;
   logic [LANES-1:0]  g_wr_en;
   logic [DATA_W-1:0] g_data, g_mask;
   logic [WFID_W-1:0] g_wfid;

   logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
   logic [LANES-1:0]  s1_wr_en_q, s1_wr_en_d, s2_wr_en_q, s2_wr_en_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
   logic [DATA_W-1:0] s1_mask_q, s1_mask_d, s2_mask_q, s2_mask_d;
   logic [WFID_W-1:0] s1_wfid_q, s1_wfid_d, s2_wfid_q, s2_wfid_d;
   logic [PORT_W-1:0] s1_port_q, s1_port_d, s2_port_q, s2_port_d;
   logic [LANES-1:0]  fwd_hit_q, fwd_hit_d;
   logic [DATA_W-1:0] fwd_q, fwd_d;
   logic [DATA_W-1:0] old_data, merged;

   sgpr_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .ARB_MODE  (ARB_MODE)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .gnt     (gnt),
      .gnt_any (gnt_any),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      g_addr  = '0;
      g_wr_en = '0;
      g_data  = '0;
      g_mask  = '0;
      g_wfid  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt[p]) begin
            g_addr  = req_addr[p*ADDR_W +: ADDR_W];
            g_wr_en = req_wr_en[p*LANES +: LANES];
            g_data  = req_data[p*DATA_W +: DATA_W];
            g_mask  = req_mask[p*DATA_W +: DATA_W];
            g_wfid  = req_wfid[p*WFID_W +: WFID_W];
         end
      end
   end

   // A forwarded lane replaces the register-file read, which cannot yet see the write in S2.
   always_comb begin
      old_data = rf_rd_data;
      for (int i = 0; i < LANES; i++) begin
         if (fwd_hit_q[i]) old_data[i*WORD_W +: WORD_W] = fwd_q[i*WORD_W +: WORD_W];
      end
      merged = (s2_data_q & s2_mask_q) | (old_data & ~s2_mask_q);
   end

   always_comb begin
      s1_v_d     = gnt_any;
      s1_addr_d  = s1_addr_q;
      s1_wr_en_d = s1_wr_en_q;
      s1_data_d  = s1_data_q;
      s1_mask_d  = s1_mask_q;
      s1_wfid_d  = s1_wfid_q;
      s1_port_d  = s1_port_q;
      if (gnt_any) begin
         s1_addr_d  = g_addr;
         s1_wr_en_d = g_wr_en;
         s1_data_d  = g_data;
         s1_mask_d  = g_mask;
         s1_wfid_d  = g_wfid;
         s1_port_d  = gnt_idx;
      end

      s2_v_d     = s1_v_q;
      s2_addr_d  = s2_addr_q;
      s2_wr_en_d = s2_wr_en_q;
      s2_data_d  = s2_data_q;
      s2_mask_d  = s2_mask_q;
      s2_wfid_d  = s2_wfid_q;
      s2_port_d  = s2_port_q;
      fwd_hit_d  = '0;
      fwd_d      = fwd_q;
      if (s1_v_q) begin
         s2_addr_d  = s1_addr_q;
         s2_wr_en_d = s1_wr_en_q;
         s2_data_d  = s1_data_q;
         s2_mask_d  = s1_mask_q;
         s2_wfid_d  = s1_wfid_q;
         s2_port_d  = s1_port_q;
         fwd_d      = merged;
         if (s2_v_q && s2_addr_q == s1_addr_q) fwd_hit_d = s2_wr_en_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q     <= 1'b0;
         s1_addr_q  <= '0;
         s1_wr_en_q <= '0;
         s1_data_q  <= '0;
         s1_mask_q  <= '0;
         s1_wfid_q  <= '0;
         s1_port_q  <= '0;
         s2_v_q     <= 1'b0;
         s2_addr_q  <= '0;
         s2_wr_en_q <= '0;
         s2_data_q  <= '0;
         s2_mask_q  <= '0;
         s2_wfid_q  <= '0;
         s2_port_q  <= '0;
         fwd_hit_q  <= '0;
         fwd_q      <= '0;
      end else begin
         s1_v_q     <= s1_v_d;
         s1_addr_q  <= s1_addr_d;
         s1_wr_en_q <= s1_wr_en_d;
         s1_data_q  <= s1_data_d;
         s1_mask_q  <= s1_mask_d;
         s1_wfid_q  <= s1_wfid_d;
         s1_port_q  <= s1_port_d;
         s2_v_q     <= s2_v_d;
         s2_addr_q  <= s2_addr_d;
         s2_wr_en_q <= s2_wr_en_d;
         s2_data_q  <= s2_data_d;
         s2_mask_q  <= s2_mask_d;
         s2_wfid_q  <= s2_wfid_d;
         s2_port_q  <= s2_port_d;
         fwd_hit_q  <= fwd_hit_d;
         fwd_q      <= fwd_d;
      end
   end

   assign req_ready  = gnt;
   assign rf_rd_addr = s1_addr_q;
   assign rf_wr_en   = s2_v_q ? s2_wr_en_q : '0;
   assign rf_wr_addr = s2_addr_q;
   assign rf_wr_data = s2_v_q ? merged : '0;
   assign done_valid = s2_v_q;
   assign done_port  = s2_port_q;
   assign done_wfid  = s2_wfid_q;
   assign done_addr  = s2_addr_q;
   assign done_wr_en = s2_wr_en_q;

endmodule

// File: tb/tb_sgpr_rmw_wr_pipe.sv
// Randomised and directed bench for sgpr_rmw_wr_pipe against a sequential
// register-file model; a second instance exercises fixed-priority grants.
module tb_sgpr_rmw_wr_pipe;

   localparam int NP = 10;
   localparam int AW = 9;
   localparam int WW = 32;
   localparam int LN = 4;
   localparam int IW = 6;
   localparam int PW = 4;
   localparam int DW = LN * WW;
   localparam logic [DW-1:0] ONES = {DW{1'b1}};

   typedef struct {
      int            port;
      logic [IW-1:0] wfid;
      logic [AW-1:0] addr;
      logic [LN-1:0] wr_en;
      logic [DW-1:0] data;
      logic [DW-1:0] mask;
      int            cyc;
   } req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rf_clr = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0] pend = '0;
   logic [NP-1:0] granted = '0;
   logic [AW-1:0] p_addr  [NP];
   logic [LN-1:0] p_wr_en [NP];
   logic [DW-1:0] p_data  [NP];
   logic [DW-1:0] p_mask  [NP];
   logic [IW-1:0] p_wfid  [NP];

   logic [NP-1:0]    req_ready, req_ready_fx;
   logic [NP*AW-1:0] req_addr;
   logic [NP*LN-1:0] req_wr_en;
   logic [NP*DW-1:0] req_data, req_mask;
   logic [NP*IW-1:0] req_wfid;
   logic [AW-1:0]    rf_rd_addr, rf_wr_addr, done_addr;
   logic [DW-1:0]    rf_rd_data, rf_wr_data;
   logic [LN-1:0]    rf_wr_en, done_wr_en;
   logic             done_valid;
   logic [PW-1:0]    done_port;
   logic [IW-1:0]    done_wfid;

   logic [AW-1:0] rf_rd_addr_fx, rf_wr_addr_fx, done_addr_fx;
   logic [DW-1:0] rf_wr_data_fx;
   logic [LN-1:0] rf_wr_en_fx, done_wr_en_fx;
   logic          done_valid_fx;
   logic [PW-1:0] done_port_fx;
   logic [IW-1:0] done_wfid_fx;

   always_comb begin
      req_addr  = '0;
      req_wr_en = '0;
      req_data  = '0;
      req_mask  = '0;
      req_wfid  = '0;
      for (int p = 0; p < NP; p++) begin
         req_addr[p*AW +: AW]  = p_addr[p];
         req_wr_en[p*LN +: LN] = p_wr_en[p];
         req_data[p*DW +: DW]  = p_data[p];
         req_mask[p*DW +: DW]  = p_mask[p];
         req_wfid[p*IW +: IW]  = p_wfid[p];
      end
   end

   sgpr_rmw_wr_pipe #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_W(WW), .LANES(LN),
                      .WFID_W(IW), .ARB_MODE(0)) dut (
      .clk(clk), .rst(rst), .req_valid(pend), .req_ready(req_ready),
      .req_addr(req_addr), .req_wr_en(req_wr_en), .req_data(req_data),
      .req_mask(req_mask), .req_wfid(req_wfid), .rf_rd_addr(rf_rd_addr),
      .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
      .rf_wr_data(rf_wr_data), .done_valid(done_valid), .done_port(done_port),
      .done_wfid(done_wfid), .done_addr(done_addr), .done_wr_en(done_wr_en));

   sgpr_rmw_wr_pipe #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_W(WW), .LANES(LN),
                      .WFID_W(IW), .ARB_MODE(1)) dut_fx (
      .clk(clk), .rst(rst), .req_valid(pend), .req_ready(req_ready_fx),
      .req_addr(req_addr), .req_wr_en(req_wr_en), .req_data(req_data),
      .req_mask(req_mask), .req_wfid(req_wfid), .rf_rd_addr(rf_rd_addr_fx),
      .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en_fx), .rf_wr_addr(rf_wr_addr_fx),
      .rf_wr_data(rf_wr_data_fx), .done_valid(done_valid_fx), .done_port(done_port_fx),
      .done_wfid(done_wfid_fx), .done_addr(done_addr_fx), .done_wr_en(done_wr_en_fx));

   // Register file: synchronous read of the pre-write contents, lane i at addr+i.
   logic [WW-1:0] rf_mem [512];
   always @(posedge clk) begin
      if (rf_clr) begin
         for (int k = 0; k < 512; k++) rf_mem[k] <= '0;
         rf_rd_data <= '0;
      end else begin
         for (int i = 0; i < LN; i++) begin
            rf_rd_data[i*WW +: WW] <= rf_mem[rf_rd_addr + AW'(i)];
            if (rf_wr_en[i]) rf_mem[rf_wr_addr + AW'(i)] <= rf_wr_data[i*WW +: WW];
         end
      end
   end

   logic [WW-1:0] model_reg [512];
   req_t          q[$];
   int            glog[$];
   int            ptr_m = 0;
   int            cyc = 0;
   int            n_chk = 0;
   int            n_pass = 0;
   int            n_done_obs = 0;
   logic [NP-1:0] auto_ports = '0;
   bit            rand_on = 1'b0;
   logic [DW-1:0] last_data;
   logic [LN-1:0] last_rf_wr_en, last_wr_en;
   logic [PW-1:0] last_port;

   task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [DW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic post(input int p, input logic [AW-1:0] a, input logic [LN-1:0] we,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
      p_addr[p]  = a;
      p_wr_en[p] = we;
      p_data[p]  = d;
      p_mask[p]  = m;
      p_wfid[p]  = IW'($urandom);
      pend[p]    = 1'b1;
   endtask

   // Bases are 4-aligned or disjoint so only exact-address collisions occur; 0x1FE wraps to 0..1.
   task automatic rand_req(input int p);
      logic [AW-1:0] bases [5];
      logic [DW-1:0] m;
      bases = '{9'h010, 9'h020, 9'h030, 9'h040, 9'h1FE};
      case ($urandom_range(0, 2))
         0:       m = ONES;
         1:       m = rand_word();
         default: m = '0;
      endcase
      post(p, bases[$urandom_range(0, 4)], LN'($urandom), rand_word(), m);
   endtask

   task automatic drive_edge();
      @(posedge clk);
      cyc++;
      #1;
      pend    = pend & ~granted;
      granted = '0;
   endtask

   task automatic fill();
      for (int p = 0; p < NP; p++) begin
         if (!pend[p] && (auto_ports[p] || (rand_on && $urandom_range(0, 3) == 0))) rand_req(p);
      end
   endtask

   task automatic sample();
      logic [NP-1:0] eg, ef;
      logic          exp_dv;
      logic [DW-1:0] old, exp_d, lm;
      req_t          e;
      @(negedge clk);
      eg = '0;
      ef = '0;
      if (!rst) begin
         for (int k = 0; k < NP; k++) begin
            int idx;
            idx = (ptr_m + k) % NP;
            if (eg == '0 && pend[idx]) eg[idx] = 1'b1;
         end
         for (int k = NP - 1; k >= 0; k--) begin
            if (pend[k]) begin
               ef    = '0;
               ef[k] = 1'b1;
            end
         end
      end
      chk_eq("req_ready", DW'(req_ready), DW'(eg));
      chk_eq("req_ready_fixed", DW'(req_ready_fx), DW'(ef));

      if (done_valid) n_done_obs++;
      exp_dv = (q.size() > 0) && (q[0].cyc + 2 == cyc);
      chk_eq("done_valid", DW'(done_valid), DW'(exp_dv));
      if (exp_dv) begin
         e  = q.pop_front();
         lm = '0;
         for (int i = 0; i < LN; i++) begin
            old[i*WW +: WW] = model_reg[e.addr + AW'(i)];
            if (e.wr_en[i]) lm[i*WW +: WW] = '1;
         end
         exp_d = (e.data & e.mask) | (old & ~e.mask);
         chk_eq("done_port", DW'(done_port), DW'(e.port));
         chk_eq("done_wfid", DW'(done_wfid), DW'(e.wfid));
         chk_eq("done_addr", DW'(done_addr), DW'(e.addr));
         chk_eq("done_wr_en", DW'(done_wr_en), DW'(e.wr_en));
         chk_eq("rf_wr_en", DW'(rf_wr_en), DW'(e.wr_en));
         chk_eq("rf_wr_addr", DW'(rf_wr_addr), DW'(e.addr));
         chk_eq("rf_wr_data", rf_wr_data & lm, exp_d & lm);
         for (int i = 0; i < LN; i++) begin
            if (e.wr_en[i]) model_reg[e.addr + AW'(i)] = exp_d[i*WW +: WW];
         end
         last_data     = rf_wr_data;
         last_rf_wr_en = rf_wr_en;
         last_wr_en    = done_wr_en;
         last_port     = done_port;
      end else begin
         chk_eq("rf_wr_en_idle", DW'(rf_wr_en), '0);
      end

      foreach (q[j]) begin
         if (q[j].cyc + 1 == cyc) chk_eq("rf_rd_addr", DW'(rf_rd_addr), DW'(q[j].addr));
      end

      for (int k = 0; k < NP; k++) begin
         if (req_ready[k] && pend[k]) begin
            e.port  = k;
            e.wfid  = p_wfid[k];
            e.addr  = p_addr[k];
            e.wr_en = p_wr_en[k];
            e.data  = p_data[k];
            e.mask  = p_mask[k];
            e.cyc   = cyc;
            q.push_back(e);
            glog.push_back(k);
            granted[k] = 1'b1;
            ptr_m = (k + 1) % NP;
         end
      end
      if (rst) begin
         q.delete();
         ptr_m = 0;
      end
   endtask

   task automatic step();
      drive_edge();
      fill();
      sample();
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40 && (pend != '0 || granted != '0 || q.size() != 0); n++) step();
      chk_eq("drain_pending", DW'(pend), '0);
      chk_eq("drain_inflight", DW'(q.size()), '0);
   endtask

   initial begin
      int            n0;
      logic [DW-1:0] d;
      int            exp_order [6];
      exp_order = '{0, 3, 9, 0, 3, 9};
      for (int p = 0; p < NP; p++) begin
         p_addr[p]  = '0;
         p_wr_en[p] = '0;
         p_data[p]  = '0;
         p_mask[p]  = '0;
         p_wfid[p]  = '0;
      end
      for (int k = 0; k < 512; k++) model_reg[k] = '0;

      // Port 2 waits through reset and must be granted only once rst falls.
      post(2, 9'h040, 4'hF, rand_word(), ONES);
      repeat (3) begin
         drive_edge();
         sample();
      end
      chk_eq("rst_rf_rd_addr", DW'(rf_rd_addr), '0);
      chk_eq("rst_rf_wr_addr", DW'(rf_wr_addr), '0);
      chk_eq("rst_rf_wr_data", rf_wr_data, '0);
      chk_eq("rst_done_addr", DW'(done_addr), '0);
      chk_eq("rst_done_port", DW'(done_port), '0);
      chk_eq("rst_done_wfid", DW'(done_wfid), '0);
      chk_eq("rst_done_wr_en", DW'(done_wr_en), '0);
      drive_edge();
      rst    = 1'b0;
      rf_clr = 1'b0;
      sample();
      chk_eq("resume_grant", DW'(req_ready), DW'(10'b00_0000_0100));
      wait_idle();

      // Single masked write over 0xAAAA_AAAA.
      drive_edge();
      post(0, 9'd5, 4'b0001, DW'(32'hAAAA_AAAA), ONES);
      sample();
      wait_idle();
      drive_edge();
      post(0, 9'd5, 4'b0001, DW'(32'h1234_5678), DW'(32'h0000_FFFF));
      sample();
      wait_idle();
      chk_eq("masked_lane0", DW'(last_data[WW-1:0]), DW'(32'hAAAA_5678));
      chk_eq("masked_port", DW'(last_port), '0);

      // Back-to-back same address, second write must see the first via forwarding.
      drive_edge();
      post(0, 9'd7, 4'b0001, '0, ONES);
      sample();
      wait_idle();
      drive_edge();
      post(1, 9'd7, 4'b0001, DW'(32'h11), DW'(32'h0000_00FF));
      post(2, 9'd7, 4'b0001, DW'(32'h2200), DW'(32'h0000_FF00));
      sample();
      wait_idle();
      chk_eq("fwd_lane0", DW'(last_data[WW-1:0]), DW'(32'h0000_2211));

      // 128-bit LSU write, full mask.
      d = rand_word();
      drive_edge();
      post(8, 9'h010, 4'hF, d, ONES);
      sample();
      wait_idle();
      chk_eq("lsu_wr_en", DW'(last_rf_wr_en), DW'(4'hF));
      chk_eq("lsu_data", last_data, d);

      // Zero write enable still completes.
      n0 = n_done_obs;
      drive_edge();
      post(4, 9'h020, 4'h0, rand_word(), rand_word());
      sample();
      wait_idle();
      chk_eq("zero_done_count", DW'(n_done_obs - n0), DW'(1));
      chk_eq("zero_port", DW'(last_port), DW'(4));
      chk_eq("zero_done_wr_en", DW'(last_wr_en), '0);
      chk_eq("zero_rf_wr_en", DW'(last_rf_wr_en), '0);

      // Reset one cycle after a grant discards the write.
      drive_edge();
      post(5, 9'h030, 4'hF, rand_word(), ONES);
      sample();
      chk_eq("rst_test_grant", DW'(req_ready), DW'(10'b00_0010_0000));
      n0 = n_done_obs;
      drive_edge();
      rst = 1'b1;
      sample();
      drive_edge();
      rst = 1'b0;
      sample();
      step();
      step();
      chk_eq("rst_no_done", DW'(n_done_obs - n0), '0);

      // Round-robin fairness from a freshly reset pointer.
      glog.delete();
      auto_ports = 10'b10_0000_1001;
      repeat (6) step();
      auto_ports = '0;
      for (int i = 0; i < 6; i++) begin
         chk_eq("rr_order", DW'((i < glog.size()) ? glog[i] : -1), DW'(exp_order[i]));
      end
      wait_idle();

      // Random traffic with occasional single-cycle resets.
      rand_on = 1'b1;
      for (int n = 0; n < 600; n++) begin
         drive_edge();
         rst = ($urandom_range(0, 99) == 0);
         fill();
         sample();
      end
      rand_on = 1'b0;
      drive_edge();
      rst = 1'b0;
      sample();
      wait_idle();
      step();
      step();
      for (int k = 0; k < 512; k++) chk_eq("rf_contents", DW'(rf_mem[k]), DW'(model_reg[k]));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
